// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default geometry,
// FSM state encoding and the queue entry layout.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_INSTR_W  = 16;
    localparam int unsigned DEF_RESET_PC = 0;
    localparam int unsigned DEF_DEPTH    = 2;

    // FETCH may issue or hold a request; DRAIN waits out a squashed request.
    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: instruction-memory request/ack, decode valid/ready
// and the redirect input from execute. master = fetch unit side.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W  = fetch_pkg::DEF_ADDR_W,
    parameter int unsigned INSTR_W = fetch_pkg::DEF_INSTR_W
) ();

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ack;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;

    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        output redirect_valid, redirect_pc
    );

endinterface : fetch_unit_if

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO holding fetched {pc, instr} words. Flush empties it
// in one cycle and takes priority over a same-cycle push or pop.
module fetch_queue #(
    parameter int unsigned DEPTH = fetch_pkg::DEF_DEPTH,
    parameter int unsigned WIDTH = fetch_pkg::DEF_ADDR_W + fetch_pkg::DEF_INSTR_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic             head_valid_o,
    output logic [WIDTH-1:0] head_data_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && (count_q < FULL_CNT);
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; it is only ever read through count_q, and
    // leaving it unreset lets it map onto plain flops or LUT RAM.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_data_o  = head_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time,
// queues returned words and drains squashed requests after a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned INSTR_W  = DEF_INSTR_W,
    parameter int unsigned RESET_PC = DEF_RESET_PC,
    parameter int unsigned DEPTH    = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master fetch_bus
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] RESET_ADR = ADDR_W'(RESET_PC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q;
    logic              outstanding_q;

    logic               req;
    logic               ack;
    logic [ADDR_W-1:0]  addr;
    logic               push;
    logic               pop;
    logic               flush;
    logic [CNT_W-1:0]   count;
    logic               head_valid;
    logic [ENTRY_W-1:0] head_data;

    // An outstanding request keeps its original address even after a redirect
    // has moved the PC, so memory always sees a stable request.
    assign addr = outstanding_q ? req_addr_q : pc_q;
    assign req  = !reset && (outstanding_q || (count < FULL_CNT));
    assign ack  = req && fetch_bus.imem_ack;
    assign pop  = head_valid && fetch_bus.instr_ready;

    // NOTE: every always_comb output gets a default first so that no path
    // through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (fetch_bus.redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = fetch_bus.redirect_pc;
                    if (req && !ack) state_d = DRAIN;
                end else if (ack) begin
                    push = 1'b1;
                    pc_d = pc_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (fetch_bus.redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = fetch_bus.redirect_pc;
                end
                if (ack) state_d = FETCH;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_ADR;
            req_addr_q    <= RESET_ADR;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= req && !ack;
            if (req) req_addr_q <= addr;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_data_i  ({addr, fetch_bus.imem_rdata}),
        .pop_i        (pop),
        .flush_i      (flush),
        .count_o      (count),
        .head_valid_o (head_valid),
        .head_data_o  (head_data)
    );

    assign fetch_bus.imem_req    = req;
    assign fetch_bus.imem_addr   = addr;
    assign fetch_bus.instr_valid = head_valid;
    assign fetch_bus.instr_pc    = head_data[ENTRY_W-1:INSTR_W];
    assign fetch_bus.instr       = head_data[INSTR_W-1:0];

endmodule : fetch_unit
